// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the burst RAM slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_BURST,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address and burst legality for one channel.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  legal_o
);

  localparam int LANE_BITS = $clog2(STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size_i;
    incr      = addr_i + step;
    // Wrap window is (len+1) beats of 2^size bytes, aligned to its own size.
    wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr_o = addr_i;
    endcase

    legal_o = (burst_i != 2'b11) &&
              (size_i <= 3'(LANE_BITS)) &&
              ((burst_i != BURST_WRAP) || (len_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end

endmodule

// File: rtl/axi_burst_ram_slave.sv
// AXI4 burst slave backed by a word-addressed RAM; independent read and
// write channels, one outstanding transaction each, read-first on collision.
module axi_burst_ram_slave
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int LANE_BITS = $clog2(STRB_WIDTH);
  localparam int DEPTH     = 2 ** (ADDR_WIDTH - LANE_BITS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic unused_sideband;
  assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot};

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_err_q;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_legal;
  logic                  aw_hs, w_fire, w_last_beat;

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_fire      = s_axi_wvalid && s_axi_wready;
  assign w_last_beat = (w_cnt_q == 8'd0);
  assign s_axi_bid   = w_id_q;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_w_addr_gen (
    .addr_i      (w_addr_q),
    .size_i      (w_size_q),
    .len_i       (w_len_q),
    .burst_i     (w_burst_q),
    .next_addr_o (w_next_addr),
    .legal_o     (w_legal)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) w_state_q <= W_IDLE;
    else     w_state_q <= w_state_d;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves w_state_d unassigned (no latch).
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (s_axi_awvalid) w_state_d = W_BURST;
      W_BURST: if (s_axi_wvalid && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    case (w_state_q)
      W_IDLE:  s_axi_awready = 1'b1;
      W_BURST: s_axi_wready  = 1'b1;
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = (w_err_q || !w_legal) ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else if (aw_hs) begin
      w_id_q    <= s_axi_awid;
      w_addr_q  <= s_axi_awaddr;
      w_len_q   <= s_axi_awlen;
      w_cnt_q   <= s_axi_awlen;
      w_size_q  <= s_axi_awsize;
      w_burst_q <= s_axi_awburst;
      w_err_q   <= 1'b0;
    end else if (w_fire) begin
      w_addr_q <= w_next_addr;
      w_cnt_q  <= w_cnt_q - 8'd1;
      // The beat counter ends the burst; a misplaced wlast only flags SLVERR.
      if (s_axi_wlast != w_last_beat) w_err_q <= 1'b1;
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst and only the control flops clear.
  always_ff @(posedge clk) begin
    if (w_fire && w_legal && !rst) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem_q[w_addr_q[ADDR_WIDTH-1:LANE_BITS]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q, r_cnt_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;
  logic                  rvalid_q, rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  r_idle, ar_hs, r_load, r_legal;
  logic [ADDR_WIDTH-1:0] r_cur_addr, r_next_addr;
  logic [2:0]            r_cur_size;
  logic [7:0]            r_cur_len;
  logic [1:0]            r_cur_burst;
  logic [DATA_WIDTH-1:0] rd_data;

  // In IDLE the generator sees the incoming AR fields so beat 0 is read on the handshake.
  assign r_idle      = (r_state_q == R_IDLE);
  assign r_cur_addr  = r_idle ? s_axi_araddr  : r_addr_q;
  assign r_cur_size  = r_idle ? s_axi_arsize  : r_size_q;
  assign r_cur_len   = r_idle ? s_axi_arlen   : r_len_q;
  assign r_cur_burst = r_idle ? s_axi_arburst : r_burst_q;
  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign r_load      = (r_state_q == R_BURST) && (!rvalid_q || s_axi_rready);
  assign rd_data     = r_legal ? mem_q[r_cur_addr[ADDR_WIDTH-1:LANE_BITS]] : '0;

  assign s_axi_rid    = r_id_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rvalid = rvalid_q;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_r_addr_gen (
    .addr_i      (r_cur_addr),
    .size_i      (r_cur_size),
    .len_i       (r_cur_len),
    .burst_i     (r_cur_burst),
    .next_addr_o (r_next_addr),
    .legal_o     (r_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state_q <= R_IDLE;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (s_axi_arvalid) r_state_d = R_BURST;
      R_BURST: if (rvalid_q && s_axi_rready && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (r_state_q == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else if (ar_hs) begin
      r_id_q    <= s_axi_arid;
      r_len_q   <= s_axi_arlen;
      r_size_q  <= s_axi_arsize;
      r_burst_q <= s_axi_arburst;
      r_addr_q  <= r_next_addr;
      r_cnt_q   <= 8'd0;
      rvalid_q  <= 1'b1;
      rlast_q   <= (s_axi_arlen == 8'd0);
      rresp_q   <= r_legal ? RESP_OKAY : RESP_SLVERR;
      rdata_q   <= rd_data;
    end else if (r_load) begin
      if (rlast_q) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end else begin
        r_addr_q <= r_next_addr;
        r_cnt_q  <= r_cnt_q + 8'd1;
        rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
        rdata_q  <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Scoreboard bench for axi_burst_ram_slave: expected B and R beats are queued
// from a reference memory model when a transaction is issued.
module tb_axi_burst_ram_slave;
  import axi_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awlock, s_axi_arlock;
  logic [3:0]    s_axi_awcache, s_axi_arcache;
  logic          s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [SW-1:0] s_axi_wstrb;
  logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_burst_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } rbeat_t;

  typedef struct {
    logic [1:0]    resp;
    logic [IW-1:0] id;
  } bexp_t;

  rbeat_t        rq[$];
  bexp_t         bq[$];
  logic [DW-1:0] mm[int];
  logic [DW-1:0] wbuf[16];
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference wrap computed by division rather than masking.
  function automatic logic [AW-1:0] m_next(input logic [AW-1:0] a, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst);
    int step, bnd, base;
    step = 1 << size;
    case (burst)
      2'b01: return a + AW'(step);
      2'b10: begin
        bnd  = (int'(len) + 1) * step;
        base = (int'(a) / bnd) * bnd;
        return AW'(base + ((int'(a) - base + step) % bnd));
      end
      default: return a;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    if (burst == 2'b11) return 1'b0;
    if (size > 3'd2) return 1'b0;
    if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    int k;
    k = int'(a >> 2);
    return mm.exists(k) ? mm[k] : '0;
  endfunction

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [SW-1:0] strb,
                          input int early, input string tag);
    bexp_t         e;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    bit            ok;
    int            n;
    ok     = m_legal(size, len, burst);
    e.id   = id;
    e.resp = (ok && early < 0) ? RESP_OKAY : RESP_SLVERR;
    bq.push_back(e);
    a = addr;
    if (ok) begin
      for (int i = 0; i <= int'(len); i++) begin
        w = m_rd(a);
        for (int b = 0; b < SW; b++) if (strb[b]) w[8*b +: 8] = wbuf[i][8*b +: 8];
        mm[int'(a >> 2)] = w;
        a = m_next(a, size, len, burst);
      end
    end

    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    check({tag, "_awready"}, s_axi_awready, 1);
    tick();
    s_axi_awvalid = 1'b0;

    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wbuf[i];
      s_axi_wstrb  = strb;
      s_axi_wlast  = (early < 0) ? (i == int'(len)) : (i == early);
      n = 0;
      while (!s_axi_wready && n < 50) begin tick(); n++; end
      check({tag, "_wready"}, s_axi_wready, 1);
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;

    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    check({tag, "_bvalid"}, s_axi_bvalid, 1);
    e = bq.pop_front();
    check({tag, "_bid"}, s_axi_bid, e.id);
    check({tag, "_bresp"}, s_axi_bresp, e.resp);
    tick();
    s_axi_bready = 1'b0;
    check({tag, "_awready_after"}, s_axi_awready, 1);
    check({tag, "_bvalid_after"}, s_axi_bvalid, 0);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [15:0] pat,
                         input bit b2b, input string tag);
    rbeat_t        e;
    logic [AW-1:0] a;
    logic [DW-1:0] hd;
    logic [1:0]    hr;
    logic          hl, held, ok;
    int            n, got, cyc, last_cyc;
    ok = m_legal(size, len, burst);
    a  = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = ok ? m_rd(a) : '0;
      e.resp = ok ? RESP_OKAY : RESP_SLVERR;
      e.last = (i == int'(len));
      e.id   = id;
      rq.push_back(e);
      a = m_next(a, size, len, burst);
    end

    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    check({tag, "_arready"}, s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    check({tag, "_latency"}, s_axi_rvalid, 1);

    got = 0; cyc = 0; last_cyc = -1;
    while (got <= int'(len) && cyc < 100) begin
      s_axi_rready = pat[cyc % 16];
      held = s_axi_rvalid && !s_axi_rready;
      hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast;
      if (s_axi_rvalid && s_axi_rready) begin
        e = rq.pop_front();
        check({tag, "_rdata"}, s_axi_rdata, e.data);
        check({tag, "_rresp"}, s_axi_rresp, e.resp);
        check({tag, "_rlast"}, s_axi_rlast, e.last);
        check({tag, "_rid"}, s_axi_rid, e.id);
        if (s_axi_rlast) last_cyc = cyc;
        got++;
      end
      tick();
      cyc++;
      if (held) begin
        check({tag, "_stall_valid"}, s_axi_rvalid, 1);
        check({tag, "_stall_data"}, s_axi_rdata, hd);
        check({tag, "_stall_resp"}, s_axi_rresp, hr);
        check({tag, "_stall_last"}, s_axi_rlast, hl);
      end
    end
    s_axi_rready = 1'b0;
    check({tag, "_beats"}, got, int'(len) + 1);
    check({tag, "_rvalid_after"}, s_axi_rvalid, 0);
    if (b2b) check({tag, "_b2b"}, last_cyc, int'(len));
  endtask

  initial begin
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;

    repeat (3) tick();
    check("rst_awready", s_axi_awready, 1);
    check("rst_arready", s_axi_arready, 1);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_bid", s_axi_bid, 0);
    check("rst_rid", s_axi_rid, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_rdata", s_axi_rdata, 0);
    rst = 1'b0;
    tick();

    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_write(8'h21, 16'h0100, 8'd3, 3'd2, BURST_INCR, 4'hF, -1, "incr_wr");
    do_read(8'h42, 16'h0100, 8'd3, 3'd2, BURST_INCR, 16'hFFFF, 1'b1, "incr_rd");
    s_axi_arlock = 1'b1;
    do_read(8'h43, 16'h0108, 8'd3, 3'd2, BURST_WRAP, 16'hFFFF, 1'b1, "wrap_rd");
    s_axi_arlock = 1'b0;
    do_read(8'h44, 16'h0100, 8'd3, 3'd2, BURST_INCR, 16'hFFF9, 1'b0, "stall_rd");
    do_read(8'h45, 16'h0104, 8'd2, 3'd2, BURST_FIXED, 16'hFFFF, 1'b1, "fixed_rd");

    wbuf[0] = 32'hAABBCCDD;
    do_write(8'h01, 16'h0200, 8'd0, 3'd2, BURST_INCR, 4'hF, -1, "strb_init");
    wbuf[0] = 32'h11223344;
    do_write(8'h02, 16'h0200, 8'd0, 3'd2, BURST_INCR, 4'h3, -1, "strb_wr");
    do_read(8'h03, 16'h0200, 8'd0, 3'd2, BURST_INCR, 16'hFFFF, 1'b1, "strb_rd");

    wbuf[0] = 32'h55; wbuf[1] = 32'h66; wbuf[2] = 32'h77; wbuf[3] = 32'h88;
    do_write(8'h04, 16'h0300, 8'd3, 3'd2, BURST_INCR, 4'hF, 1, "early_last");

    wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'hCAFEF00D;
    do_write(8'h05, 16'h0100, 8'd1, 3'd2, 2'b11, 4'hF, -1, "rsv_wr");
    do_read(8'h06, 16'h0100, 8'd1, 3'd2, 2'b11, 16'hFFFF, 1'b1, "rsv_rd");
    do_read(8'h07, 16'h0100, 8'd1, 3'd2, BURST_INCR, 16'hFFFF, 1'b1, "rsv_chk");
    do_read(8'h08, 16'h0100, 8'd0, 3'd3, BURST_INCR, 16'hFFFF, 1'b1, "size_err");
    do_read(8'h09, 16'h0100, 8'd2, 3'd2, BURST_WRAP, 16'hFFFF, 1'b1, "wraplen_err");

    // Reset pulse while beat 2 of an 8-beat read is on the bus.
    s_axi_arid = 8'h0A; s_axi_araddr = 16'h0100; s_axi_arlen = 8'd7;
    s_axi_arsize = 3'd2; s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    begin
      int n;
      n = 0;
      while (!s_axi_arready && n < 50) begin tick(); n++; end
    end
    check("rst_rd_arready", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_rd_valid", s_axi_rvalid, 1);
      check("rst_rd_data", s_axi_rdata, m_rd(16'h0100 + 16'(4 * i)));
      tick();
    end
    check("rst_rd_beat2_valid", s_axi_rvalid, 1);
    rst = 1'b1;
    s_axi_rready = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_rvalid", s_axi_rvalid, 0);
    check("rst_mid_arready", s_axi_arready, 1);
    check("rst_mid_rlast", s_axi_rlast, 0);
    check("rst_mid_awready", s_axi_awready, 1);
    tick();
    do_read(8'h0B, 16'h0100, 8'd3, 3'd2, BURST_INCR, 16'hFFFF, 1'b1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_ram_slave.md
Name: axi_burst_ram_slave

Overview:
AXI4 slave (responder) terminating one master port of the AXI interconnect, e.g. m01. It is backed by an internal word-addressed RAM and supports FIXED, INCR and WRAP bursts with independent read and write channels. It serves as the on-chip scratchpad/MMIO memory behind the interconnect.

Parameters:
DATA_WIDTH, 32, data bus width in bits (8/16/32/64)
ADDR_WIDTH, 16, byte-address width; RAM depth = 2^ADDR_WIDTH / STRB_WIDTH words
STRB_WIDTH, DATA_WIDTH/8, byte lanes
ID_WIDTH, 8, AXI ID width

Ports:
clk  in  1  clock
rst  in  1  reset
s_axi_awid / awaddr / awlen / awsize / awburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  write address
s_axi_awlock / awcache / awprot  in  1 / 4 / 3  accepted, ignored
s_axi_awvalid  in  1;  s_axi_awready  out  1
s_axi_wdata / wstrb / wlast / wvalid  in  DATA_WIDTH / STRB_WIDTH / 1 / 1  write data
s_axi_wready  out  1
s_axi_bid / bresp / bvalid  out  ID_WIDTH / 2 / 1;  s_axi_bready  in  1
s_axi_arid / araddr / arlen / arsize / arburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  read address
s_axi_arlock / arcache / arprot  in  1 / 4 / 3  accepted, ignored
s_axi_arvalid  in  1;  s_axi_arready  out  1
s_axi_rid / rdata / rresp / rlast / rvalid  out  ID_WIDTH / DATA_WIDTH / 2 / 1 / 1;  s_axi_rready  in  1

Behaviour:
- Single clock clk. rst is synchronous, active-high.
- Reset: awready=1, arready=1. wready, bvalid, rvalid and rlast are 0. bid, rid, bresp, rresp and rdata are 0. RAM contents are not cleared.
- rst mid-burst aborts both FSMs to IDLE next cycle and deasserts all valids. Partially written beats remain in RAM.
- Write FSM: IDLE -> W_BURST -> W_RESP -> IDLE.
  - IDLE: awready=1. On awvalid, latch id, addr, len, size and burst, clear the error flag, set beat counter = awlen.
  - W_BURST: wready=1. Each wvalid&&wready beat writes the lanes enabled by wstrb to word addr[ADDR_WIDTH-1:log2(STRB_WIDTH)], then advances the address.
  - Error flag is set if wlast != (counter==0) on any beat.
  - Leave W_BURST after the counter==0 beat. The slave's counter governs burst end, not wlast.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY(00) or SLVERR(10). Return to IDLE on bready; awready is 1 the following cycle.
- Read FSM: IDLE -> R_BURST -> IDLE.
  - IDLE: arready=1. On arvalid, latch fields; the first RAM read is issued that cycle.
  - First rvalid appears one cycle after the AR handshake.
  - R_BURST: the rdata/rvalid register loads when (!rvalid || rready). Sustained throughput is 1 beat/cycle.
  - rdata, rresp and rlast are held stable while rvalid && !rready.
  - rlast=1 on beat arlen. The rlast&&rready handshake returns the FSM to IDLE.
- Address generation, next = f(addr, size, len, burst):
  - FIXED: addr unchanged.
  - INCR: addr + 2^size, modulo 2^ADDR_WIDTH. No 4KB check.
  - WRAP: boundary = (len+1)*2^size. Next = (addr & ~(boundary-1)) | ((addr + 2^size) & (boundary-1)).
- Error cases. Each takes the whole burst through normal handshakes with every beat/response = SLVERR; writes to RAM are suppressed and rdata=0:
  - burst=2'b11 (reserved)
  - size > log2(STRB_WIDTH)
  - WRAP with len not in {1,3,7,15}
- Exclusive access (lock=1) returns OKAY, never EXOKAY. No monitor.
- Read and write of the same word in the same cycle: read returns the old data (read-first).
- Read and write channels are fully independent, with one outstanding transaction per channel.

Decomposition:
- Package axi_pkg:
  - burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10
  - resp codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - write/read FSM state enums
- Sub-module axi_burst_addr_gen:
  - combinational next-address plus legality check for (addr, size, len, burst)
  - instantiated once per channel

Test Plan:
- INCR write, awaddr=0x0100, len=3, size=2, data 0x11..0x44, wstrb=0xF; then INCR read of the same burst -> bresp=00; rdata 0x11,0x22,0x33,0x44 back-to-back with rready=1; rlast only on the 4th beat; rid = arid.
- WRAP read, araddr=0x0108, len=3, size=2 -> word addresses 0x108, 0x10C, 0x100, 0x104, all rresp=00.
- rready toggled 1-0-0-1 during a 4-beat read -> rdata and rlast held stable during stalls; no beat lost or duplicated.
- Write with wstrb=0x3 to a word holding 0xAABBCCDD, wdata=0x11223344 -> readback 0xAABB3344. A write with wlast asserted on beat 1 of len=3 -> bresp=10.
- Burst type 2'b11 on write and read, len=1 -> bresp=10, rresp=10 on both beats, rdata=0, RAM unchanged.
- rst pulsed for 1 cycle during beat 2 of an 8-beat read -> next cycle rvalid=0, arready=1; a following read completes normally.
